uart_rx_param: RTL



---
 rtl/uart_rx_param.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-rejecting start detect, parity/stop checking,
// valid/ready output with sticky overrun. Define RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HI
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 par_bad;
    logic                 fe_acc;
    logic                 rx_meta;
    logic                 rx_s;

    logic                 bit_c;
    logic [CNT_W-1:0]     sample_pt_c;
    logic                 at_sample_c;
    logic                 fe_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef RX_MAJORITY_EN
    logic rx_h1;
    logic rx_h2;

    // History of the two previous rx_s values, voted with the current one at each sample point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
        end
    end

    assign bit_c = (rx_h2 & rx_h1) | (rx_h2 & rx_s) | (rx_h1 & rx_s);
`else
    assign bit_c = rx_s;
`endif

    assign sample_pt_c = (state == START) ? HALF_LAST : FULL_LAST;
    assign at_sample_c = (cnt == sample_pt_c);
    assign fe_c        = fe_acc | ~bit_c;

    // Receiver FSM and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            fe_acc     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            // Abandon any frame and wait for an idle line before hunting again
            state      <= WAIT_HI;
            busy       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            fe_acc     <= 1'b0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                        par_acc <= 1'b0;
                        par_bad <= 1'b0;
                        fe_acc  <= 1'b0;
                    end
                end

                START: begin
                    if (at_sample_c) begin
                        cnt <= '0;
                        if (!bit_c) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (at_sample_c) begin
                        cnt            <= '0;
                        shift[bit_idx] <= bit_c;
                        par_acc        <= par_acc ^ bit_c;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PAR: begin
                    if (at_sample_c) begin
                        cnt     <= '0;
                        par_bad <= (PARITY == 2) ? ~(par_acc ^ bit_c) : (par_acc ^ bit_c);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (at_sample_c) begin
                        cnt <= '0;
                        if (stop_idx == LAST_STOP) begin
                            stop_idx <= 1'b0;
                            fe_acc   <= 1'b0;
                            // A low stop bit may be a break; hold off until the line returns high
                            if (fe_c) begin
                                state <= WAIT_HI;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                            if (!data_valid || data_ready) begin
                                data       <= shift;
                                parity_err <= par_bad;
                                frame_err  <= fe_c;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            fe_acc   <= fe_c;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WAIT_HI: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
